// File: rtl/sync_ram_ctrl_pkg.sv
// Shared definitions for the sync_ram_ctrl scratch RAM.
// Holds the controller state encoding and the default geometry.
// Optional feature macro used by the RAM files: SYNC_RAM_PARITY_EN.
package sync_ram_ctrl_pkg;

    // Default word width and address width (DEPTH = 2**ADDR_W)
    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 4;

    // Controller states: clear sweep after reset, then normal service
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/sync_ram_ctrl_ram_array.sv
// ram_array: DEPTH x W storage with synchronous write and combinational read.
// The word width W already includes the parity bit when
// SYNC_RAM_PARITY_EN is defined, so width handling stays in the parent.
module ram_array #(
    parameter int W      = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [W-1:0]      i_wdata,
    output logic [W-1:0]      o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [W-1:0] r_mem [DEPTH];

    // Storage update: one word written per enabled clock edge
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sync_ram_ctrl.sv
// sync_ram_ctrl: single-port synchronous scratch RAM with post-reset clear
// sweep, registered read data with a Valid strobe, a Busy flag and
// write-first read-during-write behaviour.
// Optional feature macro: SYNC_RAM_PARITY_EN (stores an even parity bit per
// word and reports ParErr on reads); when undefined ParErr stays 0.
module sync_ram_ctrl
    import sync_ram_ctrl_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WR,
    input  logic              RD,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data,
    output logic [DATA_W-1:0] Out,
    output logic              Valid,
    output logic              Busy,
    output logic              ParErr
);

`ifdef SYNC_RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_out;
    logic                r_valid;
    logic                r_busy;
    logic                r_parerr;

    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [MEM_W-1:0]    w_wdata;
    logic [MEM_W-1:0]    w_rdata;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_par_mismatch;

    // Even parity bit: makes the total count of ones in {bit, data} even
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Build a stored word from a data value (adds parity when enabled)
    function automatic logic [MEM_W-1:0] make_word(input logic [DATA_W-1:0] d);
`ifdef SYNC_RAM_PARITY_EN
        return {even_par(d), d};
`else
        return d;
`endif
    endfunction

    assign w_rd_data = w_rdata[DATA_W-1:0];

`ifdef SYNC_RAM_PARITY_EN
    assign w_par_mismatch = (w_rdata[DATA_W] != even_par(w_rd_data));
`else
    assign w_par_mismatch = 1'b0;
`endif

    // Array port steering: the sweep owns the port while clearing
    always_comb begin
        w_we    = 1'b0;
        w_addr  = Address;
        w_wdata = make_word(Data);
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_addr  = r_cnt;
            w_wdata = make_word(INIT_VAL);
        end else begin
            w_we    = WR;
            w_addr  = Address;
            w_wdata = make_word(Data);
        end
    end

    ram_array #(
        .W      (MEM_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Control FSM: clear sweep, then read/write service with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_CLEAR;
            r_cnt    <= {ADDR_W{1'b0}};
            r_out    <= {DATA_W{1'b0}};
            r_valid  <= 1'b0;
            r_busy   <= 1'b1;
            r_parerr <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                        r_cnt   <= {ADDR_W{1'b0}};
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                ST_READY: begin
                    if (RD) begin
                        r_valid <= 1'b1;
                        if (WR) begin
                            // write-first: the new data is what the read returns
                            r_out    <= Data;
                            r_parerr <= 1'b0;
                        end else begin
                            r_out    <= w_rd_data;
                            r_parerr <= w_par_mismatch;
                        end
                    end else begin
                        r_out    <= r_out;
                        r_parerr <= r_parerr;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= {ADDR_W{1'b0}};
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign Out    = r_out;
    assign Valid  = r_valid;
    assign Busy   = r_busy;
    assign ParErr = r_parerr;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Directed self-checking bench for sync_ram_ctrl (default 16x4 geometry).
// Inputs change #1 after the rising edge; outputs are sampled at that point.
module tb_sync_ram_ctrl;

    logic       clk;
    logic       rst;
    logic       WR;
    logic       RD;
    logic [3:0] Address;
    logic [3:0] Data;
    logic [3:0] Out;
    logic       Valid;
    logic       Busy;
    logic       ParErr;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int n      = 0;

    sync_ram_ctrl u_dut (
        .clk     (clk),
        .rst     (rst),
        .WR      (WR),
        .RD      (RD),
        .Address (Address),
        .Data    (Data),
        .Out     (Out),
        .Valid   (Valid),
        .Busy    (Busy),
        .ParErr  (ParErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run the sweep until Busy drops (bounded); optionally drive WR+RD on one cycle.
    task automatic sweep_wait(input int inject_at, output int cycles);
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == inject_at) begin
                WR = 1'b1; RD = 1'b1; Address = 4'd2; Data = 4'hF;
            end else begin
                WR = 1'b0; RD = 1'b0;
            end
            tick();
            cycles = i;
            check("sweep_no_valid", {31'd0, Valid}, 32'd0);
            if (!Busy) break;
        end
        WR = 1'b0; RD = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] exp, input string tag);
        WR = 1'b0; RD = 1'b1; Address = a;
        tick();
        check(tag, {28'd0, Out}, {28'd0, exp});
        check({tag, "_valid"}, {31'd0, Valid}, 32'd1);
        check({tag, "_parerr"}, {31'd0, ParErr}, 32'd0);
        RD = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] d);
        WR = 1'b1; RD = 1'b0; Address = a; Data = d;
        tick();
        check("write_no_valid", {31'd0, Valid}, 32'd0);
        WR = 1'b0;
    endtask

    initial begin
        rst = 1'b0; WR = 1'b0; RD = 1'b0; Address = 4'd0; Data = 4'd0;

        // 1: reset values, sweep length, all words cleared
        #2 rst = 1'b1;
        #1;
        check("rst_out",   {28'd0, Out},    32'd0);
        check("rst_valid", {31'd0, Valid},  32'd0);
        check("rst_busy",  {31'd0, Busy},   32'd1);
        check("rst_parerr",{31'd0, ParErr}, 32'd0);
        tick();
        rst = 1'b0;
        sweep_wait(0, n);
        check("sweep_len", n, 32'd16);
        for (int a = 0; a < 16; a++) begin
            WR = 1'b0; RD = 1'b1; Address = 4'(a);
            tick();
            check("clear_read", {28'd0, Out}, 32'd0);
            check("clear_valid", {31'd0, Valid}, 32'd1);
        end
        RD = 1'b0;
        tick();
        check("idle_valid", {31'd0, Valid}, 32'd0);

        // 2: write then read, Out holds afterwards
        do_write(4'd3, 4'hA);
        check("wr_out_hold", {28'd0, Out}, 32'd0);
        do_read(4'd3, 4'hA, "rd_a3");
        tick();
        check("hold_out", {28'd0, Out}, 32'hA);
        check("hold_valid", {31'd0, Valid}, 32'd0);

        // 3: write-first read-during-write
        WR = 1'b1; RD = 1'b1; Address = 4'd5; Data = 4'h6;
        tick();
        check("wf_out", {28'd0, Out}, 32'h6);
        check("wf_valid", {31'd0, Valid}, 32'd1);
        check("wf_parerr", {31'd0, ParErr}, 32'd0);
        WR = 1'b0;
        do_read(4'd5, 4'h6, "rd_a5");

        // boundary addresses and a write that must not disturb Out
        do_write(4'd0, 4'hF);
        check("wr_keeps_out", {28'd0, Out}, 32'h6);
        do_write(4'd15, 4'h9);
        do_read(4'd0, 4'hF, "rd_a0");
        do_read(4'd3, 4'hA, "rd_a3_again");
        do_read(4'd15, 4'h9, "rd_a15");

        // 5a: async reset in READY, then 4: access attempts during sweep
        rst = 1'b1;
        #1;
        check("rdy_rst_out",   {28'd0, Out},   32'd0);
        check("rdy_rst_valid", {31'd0, Valid}, 32'd0);
        check("rdy_rst_busy",  {31'd0, Busy},  32'd1);
        tick();
        rst = 1'b0;
        sweep_wait(3, n);
        check("sweep2_len", n, 32'd16);
        do_read(4'd2, 4'h0, "rd_a2_after_sweep");
        do_read(4'd3, 4'h0, "rd_a3_cleared");
        do_read(4'd15, 4'h0, "rd_a15_cleared");

        // 5b: reset at sweep cycle 8 restarts the full sweep
        do_write(4'd7, 4'hC);
        do_read(4'd7, 4'hC, "rd_a7");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("mid_busy_before", {31'd0, Busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out",   {28'd0, Out},   32'd0);
        check("mid_rst_valid", {31'd0, Valid}, 32'd0);
        check("mid_rst_busy",  {31'd0, Busy},  32'd1);
        tick();
        rst = 1'b0;
        sweep_wait(0, n);
        check("sweep3_len", n, 32'd16);
        do_read(4'd7, 4'h0, "rd_a7_cleared");
        do_write(4'd1, 4'h7);
        do_read(4'd1, 4'h7, "rd_a1");

`ifdef SYNC_RAM_PARITY_EN
        // 6: corrupt the stored parity bit of address 1
        u_dut.u_array.r_mem[1][4] = ~u_dut.u_array.r_mem[1][4];
        WR = 1'b0; RD = 1'b1; Address = 4'd1;
        tick();
        check("par_out", {28'd0, Out}, 32'h7);
        check("par_valid", {31'd0, Valid}, 32'd1);
        check("par_err", {31'd0, ParErr}, 32'd1);
        RD = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
